gf_mul_iter: RTL

//   Iterative GF(2^W) multiplier with a parametrised field width, reduction polynomial and

---
 rtl/gf_mul_iter_pkg.sv | 27 ++
 rtl/gf_mul_iter_if.sv | 22 ++
 rtl/gf_mul_iter_step.sv | 26 ++
 rtl/gf_mul_iter.sv | 98 +++++++++
 4 files changed

// File: rtl/gf_mul_iter_pkg.sv
// Shared GF(2^W) definitions for the multiplier, MixColumns and key-schedule blocks.
package gf_pkg;

    localparam logic [8:0] AES_POLY = 9'h11B;
    localparam int         GF_MAXW  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_state_e;

    // Multiply by x modulo poly; operands are zero-extended, only the low w bits are meaningful.
    function automatic logic [GF_MAXW-1:0] gf_xtime(input logic [GF_MAXW-1:0] v,
                                                   input logic [GF_MAXW-1:0] poly,
                                                   input int unsigned        w);
        logic [GF_MAXW-1:0] mask;
        logic [GF_MAXW-1:0] res;
        mask = (w >= GF_MAXW) ? '1 : ((GF_MAXW'(1) << w) - GF_MAXW'(1));
        res  = v << 1;
        if (((v >> (w - 1)) & GF_MAXW'(1)) != '0) begin
            res = res ^ poly;
        end
        return res & mask;
    endfunction

endpackage

// File: rtl/gf_mul_iter_if.sv
// Operand/result handshake bundle for the iterative GF multiplier.
interface gf_mul_iter_if #(parameter int W = 8);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_prod;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod
    );

endinterface

// File: rtl/gf_mul_iter_step.sv
// Combinational chain of D Horner steps: acc = xtime(acc) ^ (b bit ? a : 0), MSB first.
module gf_mul_step
    import gf_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W:0]   POLY = (W+1)'(AES_POLY),
    parameter int           D    = 1
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] a_i,
    input  logic [D-1:0] b_top_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] chain;

    always_comb begin
        chain = acc_i;
        for (int i = D - 1; i >= 0; i--) begin
            chain = W'(gf_xtime(GF_MAXW'(chain), GF_MAXW'(POLY[W-1:0]), W))
                    ^ (b_top_i[i] ? a_i : '0);
        end
        acc_o = chain;
    end

endmodule

// File: rtl/gf_mul_iter.sv
// Iterative GF(2^W) multiplier, D bits of B per clock, valid/ready on both sides.
module gf_mul_iter
    import gf_pkg::*;
#(
    parameter int         W    = 8,
    parameter logic [W:0] POLY = (W+1)'(AES_POLY),
    parameter int         D    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    gf_mul_iter_if.slave  bus
);

    localparam int STEPS = W / D;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (W < 2 || W > GF_MAXW) begin : g_bad_width
        $error("gf_mul_iter: W=%0d out of range", W);
    end
    if (W % D != 0) begin : g_bad_digits
        $error("gf_mul_iter: D=%0d does not divide W=%0d", D, W);
    end
    if (POLY[W] != 1'b1) begin : g_bad_poly
        $error("gf_mul_iter: POLY bit W must be set");
    end

    gf_state_e    state_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [CW-1:0] cnt_q;
    logic [W-1:0] prod_q;
    logic         valid_q;

    gf_mul_step #(.W(W), .POLY(POLY), .D(D)) u_step (
        .acc_i   (acc_q),
        .a_i     (a_q),
        .b_top_i (b_q[W-1 -: D]),
        .acc_o   (acc_d)
    );

    // A finished result can be retired and a new pair accepted on the same edge.
    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = valid_q;
    assign bus.out_prod  = prod_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    b_q   <= b_q << D;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        prod_q  <= acc_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            a_q     <= bus.in_a;
                            b_q     <= bus.in_b;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
